// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing defaults and region encodings for the video timing path.
// No logic; imported by the sync generator and its axis counters.
package vga_sync_gen_pkg;

    localparam int COUNT_W   = 10;
    localparam int COUNT_MAX = 1 << COUNT_W;

    // 640x480@60 from a 50 MHz clock with a pixel every second clock
    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam int   DEF_CLK_DIV  = 2;
    localparam logic DEF_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FRONT  = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BACK   = 2'd3
    } region_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// count/region present the look-ahead value taken at the next edge (0-cycle decode).
// No backpressure; advances on step, clr has priority.
module vga_axis_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step,
    output logic [COUNT_W-1:0] count,
    output logic [1:0]         region,
    output logic               wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    generate
        if (TOTAL > COUNT_MAX || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
            $error("vga_axis_counter: illegal axis timing");
        end
    endgenerate

    localparam logic [COUNT_W-1:0] LAST_ACT  = COUNT_W'(ACTIVE - 1);
    localparam logic [COUNT_W-1:0] LAST_FP   = COUNT_W'(ACTIVE + FP - 1);
    localparam logic [COUNT_W-1:0] LAST_SYNC = COUNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [COUNT_W-1:0] LAST_TOT  = COUNT_W'(TOTAL - 1);

    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    region_t            r_region;
    region_t            w_region_nxt;

    assign wrap = step && (r_count == LAST_TOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_region <= REG_ACTIVE;
        end else begin
            r_count  <= w_count_nxt;
            r_region <= w_region_nxt;
        end
    end

    always_comb begin
        w_count_nxt  = r_count;
        w_region_nxt = r_region;
        if (clr) begin
            w_count_nxt  = '0;
            w_region_nxt = REG_ACTIVE;
        end else if (step) begin
            w_count_nxt = wrap ? '0 : r_count + 1'b1;
            case (r_region)
                REG_ACTIVE: if (r_count == LAST_ACT)  w_region_nxt = REG_FRONT;
                REG_FRONT:  if (r_count == LAST_FP)   w_region_nxt = REG_SYNC;
                REG_SYNC:   if (r_count == LAST_SYNC) w_region_nxt = REG_BACK;
                REG_BACK:   if (r_count == LAST_TOT)  w_region_nxt = REG_ACTIVE;
                default:                              w_region_nxt = REG_ACTIVE;
            endcase
        end
    end

    assign count  = w_count_nxt;
    assign region = w_region_nxt;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: hsync/vsync, active mask, pixel coordinates, line/frame pulses.
// Outputs registered from next-state counters: zero skew, change on the same edge as h/v.
// No backpressure; enable low synchronously clears to the reset state.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       mask,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             r_run;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic             w_clr;

    logic [COUNT_W-1:0] w_h_nxt;
    logic [COUNT_W-1:0] w_v_nxt;
    logic [1:0]         w_h_region_nxt;
    logic [1:0]         w_v_region_nxt;
    logic               w_h_wrap;
    logic               w_v_wrap;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_mask;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_line_start;
    logic       r_frame_start;

    assign w_clr  = !enable;
    assign w_tick = r_run && (r_div == DIV_LAST);

    // r_run separates "cleared" from "sitting at (0,0)": the first enabled edge
    // enters (0,0) without a tick and must still fire both pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_div <= '0;
        end else if (w_clr) begin
            r_run <= 1'b0;
            r_div <= '0;
        end else begin
            r_run <= 1'b1;
            r_div <= (!r_run || w_tick) ? '0 : r_div + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .step   (w_tick),
        .count  (w_h_nxt),
        .region (w_h_region_nxt),
        .wrap   (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .step   (w_tick & w_h_wrap),
        .count  (w_v_nxt),
        .region (w_v_region_nxt),
        .wrap   (w_v_wrap)
    );

    logic w_mask_nxt;
    assign w_mask_nxt = (w_h_region_nxt == REG_ACTIVE) && (w_v_region_nxt == REG_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_mask        <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_clr) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_mask        <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (w_h_region_nxt == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_region_nxt == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_mask        <= w_mask_nxt;
            r_x           <= w_mask_nxt ? w_h_nxt : '0;
            r_y           <= w_mask_nxt ? w_v_nxt : '0;
            r_line_start  <= !r_run || w_h_wrap;
            r_frame_start <= !r_run || w_v_wrap;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign mask        = r_mask;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing, a small CLK_DIV=2 raster for frame/disable,
// and a tiny CLK_DIV=1 raster for parameter scaling.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_d, en_m, en_t;

    logic       d_hs, d_vs, d_mask, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       m_hs, m_vs, m_mask, m_ls, m_fs;
    logic [9:0] m_x, m_y;
    logic       t_hs, t_vs, t_mask, t_ls, t_fs;
    logic [9:0] t_x, t_y;

    int checks = 0;
    int errors = 0;

    vga_sync_gen u_dut_def (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en_d),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .mask        (d_mask),
        .x           (d_x),
        .y           (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs)
    );

    // 16 pixels x 11 lines, 2 clk per pixel: 32 clk/line, 352 clk/frame
    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .CLK_DIV  (2), .SYNC_POL (1'b0)
    ) u_dut_mid (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en_m),
        .hsync       (m_hs),
        .vsync       (m_vs),
        .mask        (m_mask),
        .x           (m_x),
        .y           (m_y),
        .line_start  (m_ls),
        .frame_start (m_fs)
    );

    vga_sync_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .CLK_DIV  (1), .SYNC_POL (1'b0)
    ) u_dut_tiny (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en_t),
        .hsync       (t_hs),
        .vsync       (t_vs),
        .mask        (t_mask),
        .x           (t_x),
        .y           (t_y),
        .line_start  (t_ls),
        .frame_start (t_fs)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mask_fall, mask_rise, hs_fall, hs_rise, vs_fall;
        int ls_cnt, ls_2nd, fs_cnt, fs_2nd, vs_low, hs_low, bad, mcnt, found;
        int exp_x, exp_mask, p;
        logic prev_mask, prev_hs, prev_vs;

        rst_n = 1'b0;
        en_d  = 1'b1;
        en_m  = 1'b0;
        en_t  = 1'b0;
        repeat (5) step_clk();

        check("rst_hsync", d_hs, 1);
        check("rst_vsync", d_vs, 1);
        check("rst_mask", d_mask, 0);
        check("rst_x", d_x, 0);
        check("rst_y", d_y, 0);
        check("rst_line_start", d_ls, 0);
        check("rst_frame_start", d_fs, 0);

        // ---- default timing: three lines from the first enabled clock ----
        rst_n = 1'b1;
        step_clk();
        mask_fall = -1; mask_rise = -1; hs_fall = -1; hs_rise = -1;
        ls_cnt = 0; ls_2nd = -1; fs_cnt = 0; vs_low = 0; bad = 0;
        prev_mask = 1'b0; prev_hs = 1'b1;
        for (int i = 0; i < 4800; i++) begin
            if (i > 0) step_clk();
            if (i == 0) begin
                check("first_frame_start", d_fs, 1);
                check("first_line_start", d_ls, 1);
                check("first_mask", d_mask, 1);
                check("first_hsync", d_hs, 1);
            end
            if (i == 1) begin
                check("frame_start_one_clk", d_fs, 0);
                check("line_start_one_clk", d_ls, 0);
            end
            if (i == 1279) check("x_last_active", d_x, 639);
            if (i == 1605) check("y_line1", d_y, 1);
            if (i == 2900) check("y_blank_zero", d_y, 0);
            if (i == 3205) check("y_line2", d_y, 2);
            if (d_ls) begin
                ls_cnt++;
                if (ls_cnt == 2) ls_2nd = i;
            end
            if (d_fs) fs_cnt++;
            if (!d_vs) vs_low++;
            if (prev_mask && !d_mask && mask_fall < 0) mask_fall = i;
            if (!prev_mask && d_mask && i > 0 && mask_rise < 0) mask_rise = i;
            if (prev_hs && !d_hs && hs_fall < 0) hs_fall = i;
            if (!prev_hs && d_hs && hs_rise < 0) hs_rise = i;
            exp_mask = ((i % 1600) < 1280) ? 1 : 0;
            exp_x    = (exp_mask == 1) ? (i % 1600) / 2 : 0;
            if (int'(d_x) != exp_x || int'(d_mask) != exp_mask) bad++;
            prev_mask = d_mask;
            prev_hs   = d_hs;
        end
        check("def_mask_fall", mask_fall, 1280);
        check("def_mask_rise", mask_rise, 1600);
        check("def_hsync_fall", hs_fall, 1312);
        check("def_hsync_rise", hs_rise, 1504);
        check("def_line_start_count", ls_cnt, 3);
        check("def_line_period", ls_2nd, 1600);
        check("def_frame_start_count", fs_cnt, 1);
        check("def_vsync_low_clks", vs_low, 0);
        check("def_x_mask_pattern_errs", bad, 0);

        // ---- small raster: frame timing ----
        check("mid_disabled_hsync", m_hs, 1);
        check("mid_disabled_mask", m_mask, 0);
        en_m = 1'b1;
        step_clk();
        fs_cnt = 0; fs_2nd = -1; vs_fall = -1; vs_low = 0; bad = 0; mcnt = 0;
        prev_vs = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) step_clk();
            if (i == 0) check("mid_first_frame_start", m_fs, 1);
            if (i == 33) check("mid_y_line1", m_y, 1);
            if (i == 174) begin
                check("mid_last_px_x", m_x, 7);
                check("mid_last_px_y", m_y, 5);
                check("mid_last_px_mask", m_mask, 1);
            end
            if (i == 176) check("mid_after_last_px_mask", m_mask, 0);
            if (m_fs) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_2nd = i;
            end
            if (i < 352 && !m_vs) vs_low++;
            if (prev_vs && !m_vs && vs_fall < 0) vs_fall = i;
            if ((i % 352) >= 192 && m_mask) mcnt++;
            p = i % 352;
            exp_mask = (p < 192 && (p % 32) < 16) ? 1 : 0;
            if (int'(m_mask) != exp_mask) bad++;
            prev_vs = m_vs;
        end
        check("mid_frame_start_count", fs_cnt, 3);
        check("mid_frame_period", fs_2nd, 352);
        check("mid_vsync_fall", vs_fall, 224);
        check("mid_vsync_low_clks", vs_low, 64);
        check("mid_mask_in_vblank", mcnt, 0);
        check("mid_mask_pattern_errs", bad, 0);

        // ---- small raster: mid-frame disable at line 3 ----
        step_clk();
        check("mid_line3_y", m_y, 3);
        check("mid_line3_mask", m_mask, 1);
        en_m = 1'b0;
        step_clk();
        check("dis_hsync", m_hs, 1);
        check("dis_vsync", m_vs, 1);
        check("dis_mask", m_mask, 0);
        check("dis_x", m_x, 0);
        check("dis_y", m_y, 0);
        check("dis_line_start", m_ls, 0);
        check("dis_frame_start", m_fs, 0);
        repeat (9) step_clk();
        check("dis_held_mask", m_mask, 0);
        check("dis_held_line_start", m_ls, 0);
        en_m = 1'b1;
        step_clk();
        check("reen_frame_start", m_fs, 1);
        check("reen_line_start", m_ls, 1);
        check("reen_mask", m_mask, 1);
        check("reen_x", m_x, 0);
        check("reen_y", m_y, 0);
        found = -1;
        for (int i = 1; i <= 400; i++) begin
            step_clk();
            if (m_fs && found < 0) found = i;
        end
        check("reen_frame_period", found, 352);

        // ---- tiny raster, CLK_DIV=1 ----
        check("tiny_disabled_hsync", t_hs, 1);
        en_t = 1'b1;
        step_clk();
        hs_low = 0; hs_fall = -1; fs_cnt = 0; fs_2nd = -1; ls_cnt = 0;
        vs_low = 0; vs_fall = -1; mcnt = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int i = 0; i < 140; i++) begin
            if (i > 0) step_clk();
            if (i < 8 && !t_hs) hs_low++;
            if (prev_hs && !t_hs && hs_fall < 0) hs_fall = i;
            if (t_fs) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_2nd = i;
            end
            if (t_ls) ls_cnt++;
            if (i < 64 && !t_vs) vs_low++;
            if (prev_vs && !t_vs && vs_fall < 0) vs_fall = i;
            if (i < 64 && t_mask) mcnt++;
            prev_hs = t_hs;
            prev_vs = t_vs;
        end
        check("tiny_hsync_low_clks", hs_low, 2);
        check("tiny_hsync_fall", hs_fall, 5);
        check("tiny_frame_start_count", fs_cnt, 3);
        check("tiny_frame_period", fs_2nd, 64);
        check("tiny_line_start_count", ls_cnt, 18);
        check("tiny_vsync_low_clks", vs_low, 16);
        check("tiny_vsync_fall", vs_fall, 40);
        check("tiny_mask_clks", mcnt, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
